rr_session_master: RTL
======================

RR_SESSION_MASTER -- requirements
Module: rr_session_master

Interface
REQ-001 Parameter N_CH, default 4, number of requester channels, matching the arbiter's req/grant width.
REQ-002 Parameter LEN_W, default 4, command length field width; a session carries cmd_len+1 beats (1..16).
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_an  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered by the local side.
REQ-006 cmd_ch  input  2  target channel of the offered command.
REQ-007 cmd_len  input  LEN_W  beats minus one.
REQ-008 cmd_ready  output  1  command accepted on cmd_valid & cmd_ready at a rising edge.
REQ-009 req  output  N_CH  per-channel request to the round-robin arbiter.
REQ-010 grant  input  N_CH  one-hot grant from the arbiter, held until session_is_finished is sampled.
REQ-011 session_is_finished  output  1  one-cycle pulse ending the granted session.
REQ-012 bus_valid, bus_ready, bus_last, bus_ch[1:0]  out/in/out/out  1/1/1/2  shared beat bus; beat transfers on bus_valid & bus_ready.
REQ-013 grant_err  output  1  sticky flag, set on a multi-hot grant.

Function
REQ-014 Each channel SHALL own a 2-entry FIFO of cmd_len values.
REQ-015 cmd_ready SHALL equal ~full[cmd_ch], combinational; a full FIFO refuses a push even in its pop cycle.
REQ-016 req[i] SHALL equal ~empty[i], registered from FIFO state; no other qualification.
REQ-017 FSM states SHALL be IDLE, ACTIVE, FINISH, GAP.
REQ-018 IDLE: if grant is one-hot and grant & req nonzero, latch channel index to bus_ch, load beat counter with FIFO head + 1, go ACTIVE next cycle.
REQ-019 IDLE: a grant to a channel with req[i]=0, or grant=0, SHALL be ignored and the FSM stays in IDLE.
REQ-020 IDLE: a multi-hot grant SHALL be ignored, set grant_err, and leave grant_err set until reset.
REQ-021 ACTIVE: bus_valid=1, bus_ch holds the latched channel, and bus_last=1 when counter==1.
REQ-022 ACTIVE: the counter SHALL decrement on each accepted beat, and bus_valid, bus_ch and bus_last SHALL hold steady while bus_ready=0.
REQ-023 ACTIVE: when the last beat is accepted, the FSM SHALL go to FINISH.
REQ-024 FINISH: session_is_finished=1 for exactly one cycle, pop the latched channel's FIFO, then go to GAP.
REQ-025 GAP: one cycle with no outputs active, so the arbiter can update grant; then go to IDLE.
REQ-026 Grant changes while in ACTIVE or FINISH SHALL be ignored; the session completes on the latched channel.
REQ-027 Minimum session is 1 beat: IDLE→ACTIVE(1 cycle with bus_ready=1)→FINISH→GAP, so 4 cycles from grant sampled to next IDLE.
REQ-028 A push to the channel being popped in FINISH SHALL succeed if the FIFO is not full; count is unchanged and the new entry queues behind.
REQ-029 FIFO pointers SHALL wrap modulo 2; occupancy 0..2 and no overflow or underflow under any stimulus.

Reset
REQ-030 While rst_an=0: FSM=IDLE, all FIFOs empty, and req=0, bus_valid=0, bus_last=0, bus_ch=0, session_is_finished=0, grant_err=0, counter=0.
REQ-031 Reset asserted mid-session SHALL abort immediately, with no session_is_finished pulse and all queued commands discarded.
REQ-032 After release, the first command is accepted at the first rising edge with cmd_valid=1.

Verification
REQ-033 Push ch2 len=0, grant=0100 two cycles later, bus_ready=1 -> one beat with bus_ch=2, bus_last=1, then session_is_finished pulse, then req[2]=0.
REQ-034 Push ch1 len=3, hold grant=0010, bus_ready toggling 1,0,1,0,... -> exactly 4 accepted beats, bus_last only on the 4th, one finish pulse, outputs stable during stalls.
REQ-035 Push ch0 twice and ch0 a third time -> third push sees cmd_ready=0; req[0]=1 is held across two back-to-back sessions separated by the GAP cycle.
REQ-036 req=1100 with grant=0011 -> no session; then grant=1100 -> grant_err=1 with no session; then grant=1000 -> session on ch3, grant_err still 1.
REQ-037 Drop rst_an during beat 2 of a len=5 session -> bus_valid, req and session_is_finished are 0 immediately, with no finish pulse after release.
REQ-038 Change grant from 0010 to 0001 mid-session on ch1 -> all beats stay bus_ch=1 and the session finishes normally.

Source files
------------

// File: rtl/rr_session_master.sv
// rr_session_master: per-channel command FIFOs feeding a round-robin arbiter,
// then streaming each granted session as a burst on a shared beat bus.
module rr_session_master #(
    parameter int N_CH  = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_ch,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  grant,
    output logic             session_is_finished,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_last,
    output logic [1:0]       bus_ch,
    output logic             grant_err
);

    localparam int CW = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FINISH,
        GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LEN_W-1:0] mem [N_CH][2];
    logic [1:0]       count [N_CH];
    logic [N_CH-1:0]  wr_ptr;
    logic [N_CH-1:0]  rd_ptr;
    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  empty;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [1:0]       ch_q;
    logic [1:0]       ch_nx;
    logic             err_nx;

    logic             g_onehot;
    logic             g_multi;
    logic             g_hit;
    logic [1:0]       g_idx;
    int               g_ones;
    logic [LEN_W-1:0] head;

    // FIFO status and push/pop strobes; a full FIFO refuses pushes even while popping
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            full[i]  = (count[i] == 2'd2);
            empty[i] = (count[i] == 2'd0);
            push[i]  = cmd_valid && !full[i] && (int'(cmd_ch) == i);
            pop[i]   = (state == FINISH) && (ch_q == 2'(i)) && !empty[i];
            if (int'(cmd_ch) == i) begin
                cmd_ready = !full[i];
            end
        end
    end

    assign req    = ~empty;
    assign bus_ch = ch_q;

    // FIFO storage; contents are don't-care while the entry is invalid
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= cmd_len;
            end
        end
    end

    // FIFO pointers and occupancy, pointers wrap modulo 2
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < N_CH; i++) begin
                count[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Grant decode: one-hot test, index and overlap with pending requests
    always_comb begin
        g_idx  = 2'd0;
        g_ones = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                g_idx  = i[1:0];
                g_ones = g_ones + 1;
            end
        end
        g_onehot = (g_ones == 1);
        g_multi  = (g_ones > 1);
        g_hit    = |(grant & req);
        head     = mem[g_idx][rd_ptr[g_idx]];
    end

    // Session FSM next state and bus outputs
    always_comb begin
        state_nx            = state;
        cnt_nx              = cnt;
        ch_nx               = ch_q;
        err_nx              = grant_err;
        bus_valid           = 1'b0;
        bus_last            = 1'b0;
        session_is_finished = 1'b0;
        unique case (state)
            IDLE: begin
                if (g_multi) begin
                    err_nx = 1'b1;
                end else if (g_onehot && g_hit) begin
                    ch_nx    = g_idx;
                    cnt_nx   = CW'(head) + CW'(1);
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                bus_valid = 1'b1;
                bus_last  = (cnt == CW'(1));
                if (bus_ready) begin
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = FINISH;
                    end
                end
            end
            FINISH: begin
                session_is_finished = 1'b1;
                state_nx            = GAP;
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Session FSM registers
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state     <= IDLE;
            cnt       <= '0;
            ch_q      <= 2'd0;
            grant_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ch_q      <= ch_nx;
            grant_err <= err_nx;
        end
    end

endmodule
